dmem_arbiter: RTL and testbench

- Shares the single data-memory port (combinational read, synchronous write on clk) between the cpu load/store path and a host/debug requester (loader, test bench, future DMA).
- Fixed priority to the cpu, with a starvation counter that forces one host grant after MAX_CPU_RUN consecutive cpu wins; a losing cpu is stalled for that cycle.
- Sits between cpu and dmem in top; the cpu's ALUResult/writeData/memWrite/readData connect to the cpu_* ports, dmem to the mem_* ports.

---
 rtl/dmem_arb_pkg.sv | 22 ++
 rtl/dmem_arb_starve_ctr.sv | 46 ++++
 rtl/dmem_arbiter.sv | 137 +++++++++++++
 tb/tb_dmem_arbiter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// ============================================================================
//  dmem_arb_pkg
//  Shared types and defaults for the data-memory port arbiter.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package dmem_arb_pkg;

    localparam int DMEM_WORD = 32;

    localparam int DEFAULT_MAX_CPU_RUN = 8;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_CPU  = 2'd1,
        GNT_HOST = 2'd2
    } gnt_t;

endpackage

`default_nettype wire

// File: rtl/dmem_arb_starve_ctr.sv
// ============================================================================
//  dmem_arb_starve_ctr
//  Saturating counter of consecutive cpu wins while the host waits.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module dmem_arb_starve_ctr #(
  parameter int MAX   = 8,
  parameter int CNT_W = $clog2(MAX + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic inc,
  output logic at_max
);

  localparam logic [CNT_W-1:0] C_MAX_CNT = CNT_W'(MAX);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Clear wins over increment so a forced host grant always restarts the run.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != C_MAX_CNT)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_max = (cnt_q == C_MAX_CNT);

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ============================================================================
//  dmem_arbiter
//  Shares the data-memory port between the cpu and a host requester; cpu has
//  fixed priority, the host is forced in after MAX_CPU_RUN straight cpu wins.
//  Optional: DMEM_ARB_STATS_EN adds stall / host-grant statistic counters.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int WORD        = DMEM_WORD,
  parameter int MAX_CPU_RUN = DEFAULT_MAX_CPU_RUN,
  parameter int CNT_W       = $clog2(MAX_CPU_RUN + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cpu_req,
  input  logic            cpu_we,
  input  logic [WORD-1:0] cpu_addr,
  input  logic [WORD-1:0] cpu_wdata,
  output logic [WORD-1:0] cpu_rdata,
  output logic            cpu_stall,
  input  logic            host_valid,
  input  logic            host_we,
  input  logic [WORD-1:0] host_addr,
  input  logic [WORD-1:0] host_wdata,
  output logic            host_ready,
  output logic            host_rvalid,
  output logic [WORD-1:0] host_rdata,
  output logic            mem_we,
  output logic [WORD-1:0] mem_addr,
  output logic [WORD-1:0] mem_wdata,
  input  logic [WORD-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [31:0]     stat_stalls,
  output logic [31:0]     stat_host_grants
`endif
);

  gnt_t            w_gnt;
  logic            w_at_max;
  logic            host_rvalid_q;
  logic            host_rvalid_d;
  logic [WORD-1:0] host_rdata_q;
  logic [WORD-1:0] host_rdata_d;

  always_comb begin
    w_gnt = GNT_NONE;
    if (host_valid && (!cpu_req || w_at_max)) begin
      w_gnt = GNT_HOST;
    end else if (cpu_req) begin
      w_gnt = GNT_CPU;
    end
  end

  // Idle cycles park the address/data on the cpu path with the write disabled.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    case (w_gnt)
      GNT_HOST: begin
        mem_we    = host_we;
        mem_addr  = host_addr;
        mem_wdata = host_wdata;
      end
      GNT_CPU: begin
        mem_we = cpu_we;
      end
      default: ;
    endcase
  end

  assign host_ready = (w_gnt == GNT_HOST);
  assign cpu_stall  = cpu_req & host_ready;
  assign cpu_rdata  = mem_rdata;

  dmem_arb_starve_ctr #(
    .MAX   (MAX_CPU_RUN),
    .CNT_W (CNT_W)
  ) u_starve_ctr (
    .clk    (clk),
    .rst    (rst),
    .clear  (!host_valid || host_ready),
    .inc    (host_valid && (w_gnt == GNT_CPU)),
    .at_max (w_at_max)
  );

  always_comb begin
    host_rvalid_d = host_ready & !host_we;
    host_rdata_d  = host_rvalid_d ? mem_rdata : host_rdata_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      host_rvalid_q <= 1'b0;
      host_rdata_q  <= '0;
    end else begin
      host_rvalid_q <= host_rvalid_d;
      host_rdata_q  <= host_rdata_d;
    end
  end

  assign host_rvalid = host_rvalid_q;
  assign host_rdata  = host_rdata_q;

`ifdef DMEM_ARB_STATS_EN
  logic [31:0] stat_stalls_q;
  logic [31:0] stat_stalls_d;
  logic [31:0] stat_host_grants_q;
  logic [31:0] stat_host_grants_d;

  always_comb begin
    stat_stalls_d      = stat_stalls_q + {31'd0, cpu_stall};
    stat_host_grants_d = stat_host_grants_q + {31'd0, host_ready};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_stalls_q      <= '0;
      stat_host_grants_q <= '0;
    end else begin
      stat_stalls_q      <= stat_stalls_d;
      stat_host_grants_q <= stat_host_grants_d;
    end
  end

  assign stat_stalls      = stat_stalls_q;
  assign stat_host_grants = stat_host_grants_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ============================================================================
//  tb_dmem_arbiter
//  Directed-vector bench with an expected-response queue and a monitor.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_dmem_arbiter;

  logic        clk = 1'b1;
  logic        rst;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        host_valid, host_we;
  logic [31:0] host_addr, host_wdata;
  logic        host_ready, host_rvalid;
  logic [31:0] host_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef DMEM_ARB_STATS_EN
  logic [31:0] stat_stalls, stat_host_grants;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_rdata   (cpu_rdata),
    .cpu_stall   (cpu_stall),
    .host_valid  (host_valid),
    .host_we     (host_we),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .host_ready  (host_ready),
    .host_rvalid (host_rvalid),
    .host_rdata  (host_rdata),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
`ifdef DMEM_ARB_STATS_EN
    ,
    .stat_stalls      (stat_stalls),
    .stat_host_grants (stat_host_grants)
`endif
  );

  // Data memory model: combinational read, write on posedge.
  logic [31:0] mem [0:255];
  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
  end

  typedef struct {
    string       name;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_stall;
    logic        host_ready;
    logic        host_rvalid;
    logic [31:0] host_rdata;
    logic        chk_rd;
    logic [31:0] cpu_rdata;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: one expected entry per cycle, sampled mid-cycle on negedge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check({e.name, ".mem_we"},      {31'd0, mem_we},      {31'd0, e.mem_we});
      check({e.name, ".mem_addr"},    mem_addr,             e.mem_addr);
      check({e.name, ".mem_wdata"},   mem_wdata,            e.mem_wdata);
      check({e.name, ".cpu_stall"},   {31'd0, cpu_stall},   {31'd0, e.cpu_stall});
      check({e.name, ".host_ready"},  {31'd0, host_ready},  {31'd0, e.host_ready});
      check({e.name, ".host_rvalid"}, {31'd0, host_rvalid}, {31'd0, e.host_rvalid});
      check({e.name, ".host_rdata"},  host_rdata,           e.host_rdata);
      if (e.chk_rd) check({e.name, ".cpu_rdata"}, cpu_rdata, e.cpu_rdata);
    end
  end

  task automatic drive_cpu(input logic req, input logic we, input logic [31:0] a, input logic [31:0] d);
    cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic drive_host(input logic v, input logic we, input logic [31:0] a, input logic [31:0] d);
    host_valid = v; host_we = we; host_addr = a; host_wdata = d;
  endtask

  // Queue the expectation for the current cycle, optionally raise rst after
  // the monitor has sampled, then advance to just past the next posedge.
  task automatic cyc(input string nm, input logic we, input logic [31:0] a, input logic [31:0] wd,
                     input logic stall, input logic rdy, input logic rv, input logic [31:0] rd,
                     input logic chk_rd, input logic [31:0] crd, input logic rst_mid);
    exp_t e;
    e.name = nm; e.mem_we = we; e.mem_addr = a; e.mem_wdata = wd;
    e.cpu_stall = stall; e.host_ready = rdy; e.host_rvalid = rv; e.host_rdata = rd;
    e.chk_rd = chk_rd; e.cpu_rdata = crd;
    sb.push_back(e);
    if (rst_mid) begin
      @(negedge clk);
      #1 rst = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    rst = 1'b1;
    drive_cpu(0, 0, 0, 0);
    drive_host(0, 0, 0, 0);

    // Reset state
    cyc("reset0", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    cyc("reset1", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    rst = 1'b0;

    // Idle
    cyc("idle0", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    cyc("idle1", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);

    // Host-only write then read of 0x40
    drive_host(1, 1, 32'h40, 32'hDEADBEEF);
    cyc("h_wr", 1, 32'h40, 32'hDEADBEEF, 0, 1, 0, 0, 1, 0, 0);
    drive_host(1, 0, 32'h40, 0);
    cyc("h_rd", 0, 32'h40, 0, 0, 1, 0, 0, 1, 32'hDEADBEEF, 0);
    drive_host(0, 0, 0, 0);
    cyc("h_rsp", 0, 0, 0, 0, 0, 1, 32'hDEADBEEF, 1, 0, 0);
    cyc("h_hold", 0, 0, 0, 0, 0, 0, 32'hDEADBEEF, 1, 0, 0);

    // Continuous contention: host forced every 9th cycle
    drive_cpu(1, 0, 32'h20, 32'h11);
    drive_host(1, 1, 32'h30, 32'h55);
    for (int i = 0; i < 27; i++) begin
      if (i % 9 == 8)
        cyc("cont_host", 1, 32'h30, 32'h55, 1, 1, 0, 32'hDEADBEEF, 0, 0, 0);
      else
        cyc("cont_cpu", 0, 32'h20, 32'h11, 0, 0, 0, 32'hDEADBEEF, 1, 0, 0);
    end
`ifdef DMEM_ARB_STATS_EN
    check("stat_stalls", stat_stalls, 32'd3);
    check("stat_host_grants", stat_host_grants, 32'd5);
`endif

    // Forced host write collides with a cpu store to the same word
    drive_host(1, 1, 32'h10, 32'd7);
    for (int i = 0; i < 8; i++) begin
      drive_cpu(1, 1, 32'h80 + 32'(4 * i), 32'(i));
      cyc("st_cpu", 1, 32'h80 + 32'(4 * i), 32'(i), 0, 0, 0, 32'hDEADBEEF, 0, 0, 0);
    end
    drive_cpu(1, 1, 32'h10, 32'd5);
    cyc("st_host", 1, 32'h10, 32'd7, 1, 1, 0, 32'hDEADBEEF, 1, 0, 0);
    drive_host(0, 0, 0, 0);
    cyc("st_retry", 1, 32'h10, 32'd5, 0, 0, 0, 32'hDEADBEEF, 1, 32'd7, 0);
    drive_cpu(1, 0, 32'h10, 0);
    cyc("st_load", 0, 32'h10, 0, 0, 0, 0, 32'hDEADBEEF, 1, 32'd5, 0);
    drive_cpu(1, 0, 32'h8C, 0);
    cyc("st_load2", 0, 32'h8C, 0, 0, 0, 0, 32'hDEADBEEF, 1, 32'd3, 0);

    // Reset lands in the cycle a host read is accepted
    drive_cpu(0, 0, 0, 0);
    drive_host(1, 0, 32'h40, 0);
    cyc("rr_acc", 0, 32'h40, 0, 0, 1, 0, 32'hDEADBEEF, 1, 32'hDEADBEEF, 1);
    drive_host(0, 0, 0, 0);
    cyc("rr_inrst", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    rst = 1'b0;
    cyc("rr_post", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);

    // Reset clears a partially built starvation count
    drive_cpu(1, 0, 32'h20, 32'h11);
    drive_host(1, 1, 32'h30, 32'h55);
    for (int i = 0; i < 5; i++)
      cyc("pre_rst", 0, 32'h20, 32'h11, 0, 0, 0, 0, 0, 0, 0);
    cyc("pre_rst_mid", 0, 32'h20, 32'h11, 0, 0, 0, 0, 0, 0, 1);
    cyc("cnt_inrst", 0, 32'h20, 32'h11, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i == 8)
        cyc("post_rst_host", 1, 32'h30, 32'h55, 1, 1, 0, 0, 0, 0, 0);
      else
        cyc("post_rst_cpu", 0, 32'h20, 32'h11, 0, 0, 0, 0, 0, 0, 0);
    end
    drive_cpu(0, 0, 0, 0);
    drive_host(0, 0, 0, 0);
    @(negedge clk);
    #1;
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
